// File: rtl/rr_arbiter_param.sv
// Round-robin arbiter with optional grant locking, bounded hold time and a
// manually rotatable priority pointer. All outputs are registered.
module rr_arbiter_param #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned LOCK_GRANT = 1,
  parameter int unsigned MAX_HOLD   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               release_i,
  input  logic               change_order_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               gnt_valid_o,
  output logic [NUM_REQ-1:0] priority_order_o,
  output logic               timeout_o
);

  localparam int unsigned CntW = $clog2(MAX_HOLD + 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e             state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic               valid_q;
  logic [NUM_REQ-1:0] ptr_q;
  logic [CntW-1:0]    cnt_q;
  logic               timeout_q;

  logic [NUM_REQ-1:0] mask_hi;
  logic [NUM_REQ-1:0] masked;
  logic [NUM_REQ-1:0] sel;
  logic [NUM_REQ-1:0] ptr_after_gnt;
  logic [NUM_REQ-1:0] ptr_rot_down;
  logic [CntW-1:0]    cnt_inc;
  logic               hold_done;
  logic               req_held;
  logic               leave;
  logic               timeout_hit;

  // Pick the first requester at or above the pointer, wrapping to the lowest one.
  always_comb begin
    mask_hi = ~(ptr_q - NUM_REQ'(1));
    masked  = req_i & mask_hi;
    if (|masked) begin
      sel = masked & (~masked + NUM_REQ'(1));
    end else begin
      sel = req_i & (~req_i + NUM_REQ'(1));
    end
  end

  // Pointer rotations and grant-termination decision.
  always_comb begin
    ptr_after_gnt = {gnt_q[NUM_REQ-2:0], gnt_q[NUM_REQ-1]};
    ptr_rot_down  = {ptr_q[0], ptr_q[NUM_REQ-1:1]};
    cnt_inc       = cnt_q + CntW'(1);
    hold_done     = (cnt_inc == CntW'(MAX_HOLD));
    req_held      = |(req_i & gnt_q);
    if (LOCK_GRANT != 0) begin
      leave       = release_i | ~req_held | hold_done;
      // Release wins over a simultaneous hold expiry.
      timeout_hit = ~release_i & req_held & hold_done;
    end else begin
      leave       = 1'b1;
      timeout_hit = 1'b0;
    end
  end

  // Arbitration FSM; all outputs come straight from these registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      valid_q   <= 1'b0;
      ptr_q     <= NUM_REQ'(1);
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|req_i) begin
            gnt_q   <= sel;
            valid_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= StGrant;
          end else if (change_order_i) begin
            ptr_q <= ptr_rot_down;
          end
        end
        StGrant: begin
          if (leave) begin
            gnt_q     <= '0;
            valid_q   <= 1'b0;
            ptr_q     <= ptr_after_gnt;
            timeout_q <= timeout_hit;
            state_q   <= StIdle;
          end else begin
            // Leaving at cnt_inc == MAX_HOLD keeps the counter from wrapping.
            cnt_q <= cnt_inc;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gnt_o            = gnt_q;
  assign gnt_valid_o      = valid_q;
  assign priority_order_o = ptr_q;
  assign timeout_o        = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_param.sv
// Scoreboard bench: a locked-grant and a single-cycle-grant arbiter share the
// same stimulus; an integer-level model predicts outputs after every edge.
module tb_rr_arbiter_param;

  localparam int N       = 4;
  localparam int MAXHOLD = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic         rel;
  logic         chg;

  logic [N-1:0] gnt0, prio0, gnt1, prio1;
  logic         val0, to0, val1, to1;

  rr_arbiter_param #(.NUM_REQ(4), .LOCK_GRANT(1), .MAX_HOLD(8)) u_lock (
    .clk              (clk),
    .reset            (reset),
    .req_i            (req),
    .release_i        (rel),
    .change_order_i   (chg),
    .gnt_o            (gnt0),
    .gnt_valid_o      (val0),
    .priority_order_o (prio0),
    .timeout_o        (to0)
  );

  rr_arbiter_param #(.NUM_REQ(4), .LOCK_GRANT(0), .MAX_HOLD(8)) u_single (
    .clk              (clk),
    .reset            (reset),
    .req_i            (req),
    .release_i        (rel),
    .change_order_i   (chg),
    .gnt_o            (gnt1),
    .gnt_valid_o      (val1),
    .priority_order_o (prio1),
    .timeout_o        (to1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] g0;
    logic [N-1:0] p0;
    logic         t0;
    logic [N-1:0] g1;
    logic [N-1:0] p1;
    logic         t1;
  } exp_t;

  exp_t exp_q[$];

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state per instance: holder index (-1 = none), pointer
  // index, completed grant cycles, timeout flag.
  int holder[2];
  int ptr[2];
  int held[2];
  bit tmo[2];

  task automatic model_step(input int m, input bit r, input int reqv, input bit rl,
                            input bit ch);
    bit still;
    bit done;
    bit found;
    int i;
    tmo[m] = 1'b0;
    if (r) begin
      holder[m] = -1;
      ptr[m]    = 0;
      held[m]   = 0;
    end else if (holder[m] >= 0) begin
      held[m] = held[m] + 1;
      still   = ((reqv >> holder[m]) & 1) == 1;
      if (m == 1) done = 1'b1;
      else        done = rl || !still || (held[m] >= MAXHOLD);
      if (m == 0 && !rl && still && held[m] >= MAXHOLD) tmo[m] = 1'b1;
      if (done) begin
        ptr[m]    = (holder[m] + 1) % N;
        holder[m] = -1;
      end
    end else if (reqv != 0) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        i = (ptr[m] + k) % N;
        if (!found && ((reqv >> i) & 1) == 1) begin
          found     = 1'b1;
          holder[m] = i;
          held[m]   = 0;
        end
      end
    end else if (ch) begin
      ptr[m] = (ptr[m] + N - 1) % N;
    end
  endtask

  function automatic logic [N-1:0] onehot(input int idx);
    logic [N-1:0] v;
    v = '0;
    if (idx >= 0) v = N'(1 << idx);
    return v;
  endfunction

  // Drive one cycle of inputs, predict the post-edge outputs, queue them.
  task automatic step(input bit r, input logic [N-1:0] rq, input bit rl, input bit ch);
    exp_t e;
    reset = r;
    req   = rq;
    rel   = rl;
    chg   = ch;
    for (int m = 0; m < 2; m++) model_step(m, r, int'(rq), rl, ch);
    e.g0 = onehot(holder[0]);
    e.p0 = onehot(ptr[0]);
    e.t0 = tmo[0];
    e.g1 = onehot(holder[1]);
    e.p1 = onehot(ptr[1]);
    e.t1 = tmo[1];
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req_v);
    vectors++;
    if (act !== req_v) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, req_v);
    end
  endtask

  // Monitor: after each edge, pop the prediction for that edge and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("lock.gnt",      gnt0,                  e.g0);
        check("lock.valid",    N'(val0),              N'(|e.g0));
        check("lock.prio",     prio0,                 e.p0);
        check("lock.timeout",  N'(to0),               N'(e.t0));
        check("single.gnt",    gnt1,                  e.g1);
        check("single.valid",  N'(val1),              N'(|e.g1));
        check("single.prio",   prio1,                 e.p1);
        check("single.timeout", N'(to1),              N'(e.t1));
      end
    end
  end

  initial begin
    logic [N-1:0] rq;
    int           drain;
    reset = 1'b1;
    req   = '0;
    rel   = 1'b0;
    chg   = 1'b0;

    // Reset, then rotate the pointer downward with no requests.
    step(1, 4'b0000, 0, 0);
    step(1, 4'b0000, 1, 1);
    repeat (3) step(0, 4'b0000, 0, 1);

    // Two requesters with a release after a couple of grant cycles.
    step(1, 4'b0000, 0, 0);
    for (int c = 0; c < 12; c++) step(0, 4'b1010, (c % 4) == 2, 1);

    // Single requester held with no release: hold limit and timeout.
    step(1, 4'b0000, 0, 0);
    for (int c = 0; c < 22; c++) step(0, 4'b0001, 0, 0);

    // Release and timeout in the same cycle, release must win.
    step(1, 4'b0000, 0, 0);
    for (int c = 0; c < 10; c++) step(0, 4'b0100, c == 8, 0);

    // All requesting, release pulsed two cycles into each grant.
    step(1, 4'b0000, 0, 0);
    for (int c = 0; c < 20; c++) step(0, 4'b1111, (c % 4) == 2, 0);

    // Requester drops its request mid-grant.
    for (int c = 0; c < 6; c++) step(0, (c == 3) ? 4'b1011 : 4'b1111, 0, 0);

    // Reset landing in the middle of a grant.
    step(1, 4'b0000, 0, 0);
    step(0, 4'b0101, 0, 0);
    step(0, 4'b0101, 1, 0);
    step(0, 4'b0101, 0, 0);
    step(1, 4'b0101, 1, 1);
    step(0, 4'b0000, 0, 0);

    // Randomized traffic with requests held for stretches.
    rq = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 4) == 0) begin
        rq = ($urandom_range(0, 3) == 0) ? 4'b0000 : N'($urandom_range(0, 15));
      end
      step($urandom_range(0, 49) == 0, rq, $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0);
    end

    step(0, 4'b0000, 0, 0);
    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(negedge clk);
      drain++;
    end
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
